// File: rtl/mem_pkg.sv
// Shared type codes, FSM state type and port identifiers for the data-memory arbiter.
package mem_pkg;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [2:0] ST_B  = 3'b000;
    localparam logic [2:0] ST_H  = 3'b001;
    localparam logic [2:0] ST_W  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_LSU   = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

endpackage

// File: rtl/mem_align_check.sv
// Flags misaligned addresses and unknown load/store type codes; purely combinational.
module mem_align_check
    import mem_pkg::*;
(
    input  logic       we,
    input  logic [2:0] op_type,
    input  logic [1:0] addr,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        if (we) begin
            case (op_type)
                ST_B:    err = 1'b0;
                ST_H:    err = addr[0];
                ST_W:    err = |addr;
                default: err = 1'b1;
            endcase
        end else begin
            case (op_type)
                LD_B, LD_BU: err = 1'b0;
                LD_H, LD_HU: err = addr[0];
                LD_W:        err = |addr;
                default:     err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the LSU (port 0) and instruction fetch (port 1)
// that sequences one access at a time onto the single-port data memory.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_type,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,

    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [2:0]        load_type,
    output logic [2:0]        store_type,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       data_in,
    input  logic [31:0]       data_out
);

    state_t              state;
    state_t              state_next;
    logic                last_gnt;
    logic                can_grant;
    logic                any_gnt;

    logic                chk_we;
    logic [2:0]          chk_type;
    logic [1:0]          chk_addr;
    logic                chk_err;

    logic                lat_port;
    logic                lat_we;
    logic [2:0]          lat_type;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic                lat_err;
    logic [31:0]         resp_data;

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign can_grant = rst_n && (state == IDLE || state == RESP);
    assign p0_gnt    = can_grant && p0_req && (!p1_req || last_gnt);
    assign p1_gnt    = can_grant && p1_req && (!p0_req || !last_gnt);
    assign any_gnt   = p0_gnt || p1_gnt;

    assign chk_we   = p1_gnt ? 1'b0 : p0_we;
    assign chk_type = p1_gnt ? LD_W : p0_type;
    assign chk_addr = p1_gnt ? p1_addr[1:0] : p0_addr[1:0];

    mem_align_check u_align (
        .we      (chk_we),
        .op_type (chk_type),
        .addr    (chk_addr),
        .err     (chk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            lat_port  <= PORT_LSU;
            lat_we    <= 1'b0;
            lat_type  <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            lat_err   <= 1'b0;
        end else if (any_gnt) begin
            last_gnt  <= p1_gnt;
            lat_port  <= p1_gnt ? PORT_FETCH : PORT_LSU;
            lat_we    <= chk_we;
            lat_type  <= chk_type;
            lat_addr  <= p1_gnt ? p1_addr : p0_addr;
            lat_wdata <= p1_gnt ? 32'h0 : p0_wdata;
            lat_err   <= chk_err;
        end
    end

    assign resp_data = (!lat_we && !lat_err) ? data_out : 32'h0;

    // A faulting access still walks ISSUE and RESP so latency never depends on the error.
    always_comb begin
        state_next   = state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        load_type    = 3'b000;
        store_type   = 3'b000;
        ram_address  = '0;
        data_in      = 32'h0;
        p0_rvalid    = 1'b0;
        p0_rdata     = 32'h0;
        p0_err       = 1'b0;
        p1_rvalid    = 1'b0;
        p1_rdata     = 32'h0;
        p1_err       = 1'b0;
        case (state)
            IDLE: begin
                if (any_gnt) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = RESP;
                if (!lat_err) begin
                    mem_read_en  = !lat_we;
                    mem_write_en = lat_we;
                    ram_address  = lat_addr;
                    load_type    = lat_we ? 3'b000 : lat_type;
                    store_type   = lat_we ? lat_type : 3'b000;
                    data_in      = lat_we ? lat_wdata : 32'h0;
                end
            end
            RESP: begin
                state_next = any_gnt ? ISSUE : IDLE;
                if (lat_port == PORT_FETCH) begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = resp_data;
                    p1_err    = lat_err;
                end else begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = resp_data;
                    p0_err    = lat_err;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port `data_memory`. Port 0 is the load/store unit (read or write, any width). Port 1 is instruction fetch (word reads only). The block grants one request at a time using round-robin priority, drives the memory's control and address inputs for exactly one cycle, checks alignment and type codes, and returns read data or an error to the granted requester.

## Interface
- `ADDR_W`, default 32: address width, for both requesters and memory.
- `clk` input 1: sole clock; everything samples on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `p0_req` input 1: LSU request, held until `p0_gnt`.
- `p0_we` input 1: 1 = store, 0 = load.
- `p0_type` input 3: load code (LB 000, LH 001, LW 010, LBU 100, LHU 101) or store code (SB 000, SH 001, SW 010).
- `p0_addr` input 32 and `p0_wdata` input 32: LSU address and store data.
- `p0_gnt` output 1: request accepted this cycle; fields are latched at this edge.
- `p0_rvalid` output 1: one-cycle completion pulse, for loads and stores.
- `p0_rdata` output 32: load result; 0 for stores and errors.
- `p0_err` output 1: qualifies `p0_rvalid`; misaligned address or illegal type.
- `p1_req` input 1, `p1_addr` input 32: fetch request.
- `p1_gnt`, `p1_rvalid`, `p1_err` output 1 each; `p1_rdata` output 32: same meaning as port 0.
- `mem_read_en` output 1 and `mem_write_en` output 1: memory strobes.
- `load_type` output 3, `store_type` output 3, `ram_address` output 32, `data_in` output 32: memory inputs.
- `data_out` input 32: memory registered read data.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ISSUE: memory strobes driven for one cycle.
  - RESP: response returned to the granted port.
- Transitions:
  - IDLE→ISSUE on any grant.
  - ISSUE→RESP unconditionally.
  - RESP→ISSUE if a grant is made in RESP, else RESP→IDLE.
- Grants are made only in IDLE or RESP, at most one per cycle.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, the port that was not granted last wins.
  - `last_gnt` resets to 1, so port 0 wins the first tie.
- At the grant edge, the block latches: port id, `we`, `type`, `addr`, `wdata`, and the error flag.
  - Port 1 is always latched as a load with type LW (010).
- Error rules:
  - LW/SW with `addr[1:0]` ≠ 0.
  - LH/LHU/SH with `addr[0]` = 1.
  - Load types 011, 110, 111.
  - Store types 011 and above.
- In ISSUE:
  - If there is no error: drive `mem_read_en` = !we or `mem_write_en` = we, together with `ram_address`, `load_type`/`store_type` and `data_in` taken from the latch.
  - If there is an error: both strobes stay 0, so memory is never touched. Latency is unchanged.
- In RESP:
  - Pulse `pN_rvalid` for the latched port.
  - `pN_rdata` = `data_out` for a successful load, otherwise 0.
  - `pN_err` = the latched error flag.
- Memory address, type and data outputs are 0 whenever a strobe is low.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and `last_gnt` to 1.
- Reset asserted mid-operation: the in-flight access is abandoned and no `rvalid` is produced. A store already strobed in ISSUE may have been committed.
- Grant in cycle N → strobe in cycle N+1 → `rvalid` in cycle N+2.
- Read data is valid in RESP because the memory registers `data_out` at the ISSUE edge.
- Sustained throughput is one access per 2 cycles, achieved by granting in RESP.
- `gnt` is combinational from `req`, state and `last_gnt`.
  - It never asserts in ISSUE.
  - Both ports requesting in ISSUE are arbitrated in the following RESP cycle.
- `rvalid` and `gnt` may assert together in the same RESP cycle: `rvalid` for the old access, `gnt` for the next.
- A requester may drop `req` before `gnt`; nothing is latched in that case.

## Structure
- Package `mem_pkg` holds:
  - load codes `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`;
  - store codes `ST_B`, `ST_H`, `ST_W`;
  - the FSM state enum;
  - the port-id constants.
- Sub-module `mem_align_check`: purely combinational, inputs (`we`, `type`, `addr[1:0]`), output `err`. It is shared with a future misaligned-trap path.
- The FSM, arbitration and latch live in `mem_arbiter`.

## Test plan
- Port 0 issues SW to address 0x10 with data 0xDEADBEEF, then LW from 0x10 → `mem_write_en` for one cycle, then `p0_rdata` = 0xDEADBEEF with `p0_err` = 0, 2 cycles after the load grant.
- Both ports request continuously from reset → grants alternate p0, p1, p0, p1, … and every `rvalid` carries the matching port's data.
- Port 0 issues LH from 0x13 → no memory strobe, `p0_rvalid` with `p0_err` = 1 and `p0_rdata` = 0. The next request is granted normally.
- Port 1 fetches from 0x102 → `p1_err` = 1 and no strobe. Port 1 fetches from 0x100 holding 0x00000013 → `p1_rdata` = 0x00000013.
- Memory holds 0x80FF at 0x20; port 0 issues LB from 0x20 → 0xFFFFFFFF, then LBU from 0x21 → 0x00000080.
- Assert `rst_n` low during ISSUE of a load → all outputs drop to 0 immediately and no `rvalid` appears. After release, the first tie goes to port 0.
